sseg_scan_ctrl: RTL and testbench
=================================

# sseg_scan_ctrl

Time-multiplexed scan controller for the alarm clock's four-digit common-anode display. It shares a single combinational BCD-to-seven-segment decoder across the four digits, HH:MM, by presenting one digit at a time on `bcd_out`. It registers the returned active-high pattern as active-low cathode drive. It also adds anode sequencing with a dead cycle, frame-coherent digit snapshots, leading-zero blanking, invalid-code dash and per-digit blink for time/alarm-set modes.

## Interface
- `SCAN_DIV`, 50000: clock cycles per digit slot. Must be ≥ 2. Counter width is `$clog2(SCAN_DIV)`.
- `BLINK_FRAMES`, 125: full scan frames per blink half-period. Must be ≥ 1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  display enable; 0 forces all outputs to the off state.
- `digits`  in  16  four BCD digits; `[3:0]` = digit 0 (minutes ones) … `[15:12]` = digit 3 (hours tens).
- `blink_mask`  in  4  bit i = 1 makes digit i blink.
- `dp_mask`  in  4  bit i = 1 lights the decimal point/colon on digit i.
- `blank_lead`  in  1  1 suppresses digit 3 when its value is 0.
- `bcd_out`  out  4  BCD code to the shared decoder: `snap[idx]`, driven directly from registers.
- `sseg_in`  in  7  decoder result, active-high, bit0 = a … bit6 = g; combinational return of `bcd_out`.
- `an`  out  4  anodes, active-low, registered.
- `seg`  out  7  cathodes, active-low, registered, same bit order as `sseg_in`.
- `dp`  out  1  decimal point, active-low, registered.
- `frame_tick`  out  1  high while `cnt == 0 && idx == 0`.

## Operation
- State: `cnt` (0..SCAN_DIV-1), `idx` (2-bit digit index), `snap` (16-bit copy of `digits`), `frame_cnt` (0..BLINK_FRAMES-1), `blink_phase`.
- `cnt` increments every cycle.
  - At `cnt == SCAN_DIV-1`: `cnt` returns to 0 and `idx` increments, wrapping 3 to 0.
- Wrap (`cnt == SCAN_DIV-1 && idx == 3`):
  - `snap` loads `digits`. Mid-frame changes to `digits` never appear on screen.
  - `frame_cnt` increments. When it is `BLINK_FRAMES-1`, it instead clears to 0 and `blink_phase` toggles.
- Per-cycle registered output evaluation, with priority top to bottom:
  1. `!en`: `an = 4'hF`, `seg = 7'h7F`, `dp = 1`.
  2. `cnt == 0` (dead cycle): `an = 4'hF`. `seg` and `dp` are still computed as below.
  3. Otherwise `an = ~(4'b0001 << idx)`.
- `seg` computation for the current digit:
  - Blanked when `blink_mask[idx] && blink_phase`, or when `idx == 3 && blank_lead && snap[15:12] == 0`.
  - Blanked: `seg = 7'h7F`.
  - Else if `bcd_out > 9`: `seg = 7'b0111111` (dash, segment g only).
  - Else: `seg = ~sseg_in`.
- `dp = ~dp_mask[idx]`. It is not affected by blink or blanking; it is forced to 1 only by `!en`.
- `en` does not stop the counters; scan and blink timing continue while the display is disabled.

## Timing
- Reset values: `cnt = 0`, `idx = 0`, `frame_cnt = 0`, `blink_phase = 0`, `an = 4'hF`, `seg = 7'h7F`, `dp = 1`.
  - During reset `snap` loads `digits`, so the first frame shows the inputs present during reset.
  - After reset, `bcd_out = digits[3:0]` as sampled at reset and `frame_tick = 1`.
- Decoder round trip is zero cycles. `seg` reflects `bcd_out` one clock after `bcd_out` is presented.
- Each slot is SCAN_DIV output cycles, with `idx` changing at edge E0:
  - Cycle after E0: old anode still driven, old pattern.
  - Next cycle: `an` off; `seg`/`dp` switch to the new digit.
  - Remaining SCAN_DIV-1 cycles: new anode active.
  - No cycle ever shows a new pattern under an old anode (no ghosting).
- Frame = 4·SCAN_DIV cycles. Blink half-period = BLINK_FRAMES·4·SCAN_DIV cycles.
- Reset asserted mid-slot: the next edge applies reset values, and the slot restarts at digit 0 with a fresh `snap`.
- `en` rising: outputs resume on the next edge at the current scan position; there is no slot realignment.

## Test plan
Benches use SCAN_DIV = 4 and BLINK_FRAMES = 2.
- Reset with `digits = 16'h1234`, `en = 1`:
  - `an` sequence per slot is F, E, E, E, then F, D, D, D, then F, B, B, B, then F, 7, 7, 7.
  - `seg` = ~pattern(4), ~(3), ~(2), ~(1), i.e. 7'h19 / 7'h30 / 7'h24 / 7'h79.
  - `frame_tick` pulses every 16 cycles.
- Change `digits` from 16'h1234 to 16'h5678 while `idx = 1`: the rest of the current frame still shows 1234; the next frame shows 5678.
- `digits = 16'h0930`, `blank_lead = 1`: digit 3 `seg = 7'h7F` with its anode still cycling. With `blank_lead = 0`, digit 3 shows ~0 = 7'h40.
- `blink_mask = 4'b0011`: digits 0–1 normal for 2 frames (32 cycles), blanked to 7'h7F for the next 32 cycles, and so on. Digits 2–3 are never blanked.
- `digits[7:4] = 4'hC`: digit 1 `seg = 7'b0111111`. `dp_mask = 4'b0100`: `dp = 0` only in digit-2 slots.
- `en = 0` for 10 cycles mid-slot, then `en = 1`:
  - While disabled: `an = F`, `seg = 7F`, `dp = 1`.
  - After re-enable: scan position equals the uninterrupted count.
  - Then `rst` for 1 cycle: all reset values return and `idx = 0`.

Source files
------------

// File: rtl/sseg_scan_ctrl.sv
// Four-digit common-anode scan controller sharing one external BCD decoder.
// Adds a dead cycle per slot, frame-coherent snapshots, lead blanking, dash and blink.
module sseg_scan_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lead,
  output logic [3:0]  bcd_out,
  input  logic [6:0]  sseg_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FR_MAX  = FW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   snap;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;

  logic          slot_end;
  logic          frame_end;
  logic          blanked;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  assign slot_end   = (cnt == CNT_MAX);
  assign frame_end  = slot_end && (idx == 2'd3);
  assign frame_tick = (cnt == '0) && (idx == 2'd0);

  always_comb begin
    bcd_out = snap[3:0];
    unique case (idx)
      2'd0: bcd_out = snap[3:0];
      2'd1: bcd_out = snap[7:4];
      2'd2: bcd_out = snap[11:8];
      2'd3: bcd_out = snap[15:12];
    endcase
  end

  // Outputs are evaluated from the pre-edge scan position, so the anode
  // switches one cycle after idx and the cnt==0 slot becomes the dead cycle.
  always_comb begin
    blanked = (blink_mask[idx] && blink_phase) ||
              ((idx == 2'd3) && blank_lead && (snap[15:12] == 4'd0));
    an_nxt  = (cnt == '0) ? 4'hF : ~(4'b0001 << idx);
    dp_nxt  = ~dp_mask[idx];
    if (blanked)
      seg_nxt = '1;
    else if (bcd_out > 4'd9)
      seg_nxt = 7'b0111111;
    else
      seg_nxt = ~sseg_in;
    if (!en) begin
      an_nxt  = '1;
      seg_nxt = '1;
      dp_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      snap        <= digits;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      an          <= '1;
      seg         <= '1;
      dp          <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
      if (slot_end) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (frame_end) begin
        snap <= digits;
        if (frame_cnt == FR_MAX) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Scoreboard bench for sseg_scan_ctrl: a time-based reference model pushes expected
// outputs per clock edge; a monitor pops and compares on the falling edge.
module tb_sseg_scan_ctrl;

  localparam int D  = 4;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  blink_mask;
  logic [3:0]  dp_mask;
  logic        blank_lead;
  logic [3:0]  bcd_out;
  logic [6:0]  sseg_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  sseg_scan_ctrl #(.SCAN_DIV(D), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .en(en), .digits(digits), .blink_mask(blink_mask),
    .dp_mask(dp_mask), .blank_lead(blank_lead), .bcd_out(bcd_out),
    .sseg_in(sseg_in), .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
    logic [3:0] bcd;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Active-high segment patterns, bit0 = a ... bit6 = g.
  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0: pat = 7'h3F;  4'd1: pat = 7'h06;  4'd2: pat = 7'h5B;  4'd3: pat = 7'h4F;
      4'd4: pat = 7'h66;  4'd5: pat = 7'h6D;  4'd6: pat = 7'h7D;  4'd7: pat = 7'h07;
      4'd8: pat = 7'h7F;  4'd9: pat = 7'h6F;
      default: pat = 7'h49;
    endcase
  endfunction

  always_comb sseg_in = pat(bcd_out);

  // Reference model: scan position and blink phase derived arithmetically
  // from the number of edges since reset.
  int unsigned n = 0;
  logic [3:0]  snap_m[4];
  bit          live = 0;

  always @(posedge clk) begin
    exp_t        e;
    int unsigned c, ix, fr;
    bit          ph, blk;
    if (rst) begin
      n = 0;
      for (int i = 0; i < 4; i++) snap_m[i] = digits[4*i +: 4];
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.ft = 1'b1; e.bcd = snap_m[0];
      live = 1;
      q.push_back(e);
    end else if (live) begin
      c  = n % D;
      ix = (n / D) % 4;
      fr = n / (4 * D);
      ph = ((fr / BF) % 2) == 1;
      blk = (blink_mask[ix] && ph) || (ix == 3 && blank_lead && snap_m[3] == 4'd0);
      if (!en) begin
        e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
      end else begin
        e.an  = (c == 0) ? 4'hF : ~(4'b0001 << ix);
        e.seg = blk ? 7'h7F : (snap_m[ix] > 4'd9) ? 7'b0111111 : ~pat(snap_m[ix]);
        e.dp  = ~dp_mask[ix];
      end
      if (c == D - 1 && ix == 3)
        for (int i = 0; i < 4; i++) snap_m[i] = digits[4*i +: 4];
      n = n + 1;
      e.ft  = ((n % D) == 0) && (((n / D) % 4) == 0);
      e.bcd = snap_m[(n / D) % 4];
      q.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t g, e;
    if (q.size() > 0) begin
      e = q.pop_front();
      g = '{an: an, seg: seg, dp: dp, ft: frame_tick, bcd: bcd_out};
      compared++;
      if (g !== e) begin
        mismatched++;
        $display("FAIL scan_out t=%0t: got an=%h seg=%h dp=%b ft=%b bcd=%h, expected an=%h seg=%h dp=%b ft=%b bcd=%h",
                 $time, g.an, g.seg, g.dp, g.ft, g.bcd, e.an, e.seg, e.dp, e.ft, e.bcd);
      end
    end
  end

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  bit seen_tick;

  initial begin
    rst = 1'b1; en = 1'b1; digits = 16'h1234;
    blink_mask = 4'b0000; dp_mask = 4'b0000; blank_lead = 1'b0;
    step(2);
    compared++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_tick !== 1'b1 || bcd_out !== 4'h4) begin
      mismatched++;
      $display("FAIL reset_state t=%0t: an=%h seg=%h dp=%b ft=%b bcd=%h, expected an=F seg=7F dp=1 ft=1 bcd=4",
               $time, an, seg, dp, frame_tick, bcd_out);
    end
    rst = 1'b0;
    step(22);
    digits = 16'h5678;
    step(40);
    digits = 16'h0930; blank_lead = 1'b1;
    step(40);
    blank_lead = 1'b0;
    step(32);
    blink_mask = 4'b0011;
    step(130);
    blink_mask = 4'b0000; digits = 16'h12C4; dp_mask = 4'b0100;
    step(37);
    en = 1'b0;
    step(10);
    en = 1'b1;
    step(25);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(20);
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 7) == 0) digits = 16'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        blink_mask = 4'($urandom);
        dp_mask    = 4'($urandom);
        blank_lead = 1'($urandom);
      end
      if ($urandom_range(0, 9) == 0) en = ~en;
      rst = ($urandom_range(0, 199) == 0);
      step(1);
    end
    rst = 1'b0;
    step(4);
    seen_tick = 1'b0;
    for (int unsigned w = 0; w < 40 && !seen_tick; w++) begin
      step(1);
      if (frame_tick === 1'b1) seen_tick = 1'b1;
    end
    compared++;
    if (!seen_tick) begin
      mismatched++;
      $display("FAIL frame_tick_wait t=%0t: no frame_tick within 40 cycles", $time);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
